// File: rtl/instr_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch/sequencer.
package instr_fetch_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam logic [3:0] kOPC_HALT = 4'd0;
    localparam logic [3:0] kOPC_BEQ  = 4'd4;
    localparam logic [3:0] kOPC_BGT  = 4'd5;
    localparam logic [3:0] kOPC_BLT  = 4'd6;

    localparam int OPC_MSB     = 8;
    localparam int OPC_LSB     = 5;
    localparam int LASTBIT_POS = 0;

endpackage

// File: rtl/instr_fetch_seq_pc_next_calc.sv
// Next-PC selection: hold on halt, PC-relative taken branch, else PC+1.
// Purely combinational; all arithmetic wraps modulo 2^PC_W.
module instr_fetch_seq_pc_next_calc #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc_i,
    input  logic             halt_i,
    input  logic             take_i,
    input  logic [OFF_W-1:0] offset_i,
    output logic [PC_W-1:0]  pc_next_o
);

    logic [PC_W-1:0] off_ext;

    assign off_ext = {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};

    always_comb begin
        if (halt_i) begin
            pc_next_o = pc_i;
        end else if (take_i) begin
            pc_next_o = pc_i + off_ext;
        end else begin
            pc_next_o = pc_i + PC_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencer: owns PC, fetches from sync ROM, retires one instruction per 2 cycles.
// STALL holds EXEC in place; START is only honoured from IDLE or HALTED.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int              PC_W       = 10,
    parameter int              INSTR_W    = 9,
    parameter int              OFF_W      = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               START,
    output logic [PC_W-1:0]    IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_DATA,
    output logic [INSTR_W-1:0] INSTRUCTION,
    output logic [3:0]         OPCODE,
    output logic               LASTBIT,
    output logic               INSTR_VALID,
    input  logic               HALT,
    input  logic               BRANCH,
    input  logic               BRANCH_TAKEN,
    input  logic [OFF_W-1:0]   BRANCH_OFFSET,
    input  logic               STALL,
    output logic [PC_W-1:0]    PC,
    output logic               DONE,
    output logic [CNT_W-1:0]   INSTR_COUNT
);

    fetch_state_t        state_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     pc_d;
    logic [INSTR_W-1:0]  instr_q;
    logic                valid_q;
    logic                done_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;

    instr_fetch_seq_pc_next_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_pc_next (
        .pc_i      (pc_q),
        .halt_i    (HALT),
        .take_i    (BRANCH & BRANCH_TAKEN),
        .offset_i  (BRANCH_OFFSET),
        .pc_next_o (pc_d)
    );

    // Retire count sticks at all-ones rather than rolling over.
    assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            instr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, HALTED: begin
                    if (START) begin
                        pc_q    <= START_ADDR;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    instr_q <= IMEM_DATA;
                    valid_q <= 1'b1;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (!STALL) begin
                        pc_q    <= pc_d;
                        cnt_q   <= cnt_d;
                        valid_q <= 1'b0;
                        if (HALT) begin
                            done_q  <= 1'b1;
                            state_q <= HALTED;
                        end else begin
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IMEM_ADDR   = pc_q;
    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;
    assign OPCODE      = instr_q[OPC_MSB:OPC_LSB];
    assign LASTBIT     = instr_q[LASTBIT_POS];
    assign INSTR_VALID = valid_q;
    assign DONE        = done_q;
    assign INSTR_COUNT = cnt_q;

endmodule

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction fetch/sequencer: the producer side of the control-decode interface.
- Owns the PC, reads 9-bit instructions from a synchronous instruction ROM, and presents INSTRUCTION/OPCODE/LASTBIT to the control decoder.
- Consumes the decoder's HALT and BRANCH outputs, plus the datapath branch condition, to select the next PC.
- Sits between instruction memory and the control/datapath; one instruction in flight at a time.

Parameters:
- PC_W, 10, PC and IMEM address width.
- INSTR_W, 9, instruction width; OPCODE = INSTRUCTION[8:5], LASTBIT = INSTRUCTION[0].
- OFF_W, 8, signed branch offset width.
- START_ADDR, 0, PC loaded on START.
- CNT_W, 16, retired-instruction counter width.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- START  input  1  begin execution at START_ADDR; accepted only in IDLE or HALTED.
- IMEM_ADDR  output  PC_W  instruction ROM address.
- IMEM_DATA  input  INSTR_W  ROM data, valid one cycle after IMEM_ADDR.
- INSTRUCTION  output  INSTR_W  registered current instruction.
- OPCODE  output  4  INSTRUCTION[8:5].
- LASTBIT  output  1  INSTRUCTION[0].
- INSTR_VALID  output  1  high while in EXEC.
- HALT  input  1  decoder halt for current instruction.
- BRANCH  input  1  decoder branch for current instruction.
- BRANCH_TAKEN  input  1  datapath condition result.
- BRANCH_OFFSET  input  OFF_W  signed offset relative to the branch's own PC.
- STALL  input  1  hold current instruction in EXEC.
- PC  output  PC_W  PC of current/next instruction.
- DONE  output  1  high while in HALTED.
- INSTR_COUNT  output  CNT_W  retired instructions since last START, saturating.

Behaviour:
- States: IDLE, FETCH, EXEC, HALTED.
- Reset (async, RESET_N=0): state=IDLE, PC=START_ADDR, INSTRUCTION=0, INSTR_VALID=0, DONE=0, INSTR_COUNT=0. Outputs take these values immediately, including mid-operation; no instruction retires.
- IMEM_ADDR = PC combinationally in every state.
- IDLE: START=1 -> PC=START_ADDR, INSTR_COUNT=0, go FETCH.
- FETCH: one cycle, ROM read in progress. At the edge: INSTRUCTION<=IMEM_DATA, go EXEC.
- EXEC: INSTR_VALID=1. HALT/BRANCH/BRANCH_TAKEN/BRANCH_OFFSET are sampled at the end of the cycle.
  - STALL=1 -> remain in EXEC; INSTRUCTION, PC and count unchanged.
  - Else, priority HALT > taken branch > sequential:
    - HALT=1 -> HALTED; PC unchanged; INSTR_COUNT+1.
    - BRANCH&BRANCH_TAKEN -> PC = PC + sign_extend(BRANCH_OFFSET), modulo 2^PC_W; go FETCH; count+1.
    - Otherwise PC = PC+1, modulo 2^PC_W (PC=2^PC_W-1 wraps to 0); go FETCH; count+1.
  - BRANCH=1 with BRANCH_TAKEN=0 is sequential.
  - Taken branch with offset 0 re-executes the same instruction; this is legal.
- HALTED: DONE=1, INSTR_VALID=0. START=1 -> PC=START_ADDR, count=0, go FETCH, DONE drops next cycle.
- START outside IDLE/HALTED: ignored.
- Throughput: 2 cycles per instruction with no stalls.
- OPCODE and LASTBIT are combinational slices of the INSTRUCTION register.
- INSTR_COUNT saturates at 2^CNT_W-1.
- OPCODE 0 reaching EXEC with HALT=0 (decoder fault) is treated as sequential; no special case.

Decomposition:
- Package definitions:
  - fetch_state_t enum {IDLE, FETCH, EXEC, HALTED}.
  - Constants kOPC_HALT=4'd0, kOPC_BEQ=4'd4, kOPC_BGT=4'd5, kOPC_BLT=4'd6 for benches/assertions.
  - Field-position constants for the OPCODE and LASTBIT slices.
- Sub-module pc_next_calc (combinational): inputs PC, HALT, BRANCH&BRANCH_TAKEN, BRANCH_OFFSET; output next PC with sign extension and wrap.

Test Plan:
- Sequential run: ROM[0..2] = non-branch, ROM[3] = opcode 0; tie HALT to (OPCODE==0); START pulse -> EXEC at PC 0,1,2,3 every 2 cycles; DONE=1 after the 4th EXEC; INSTR_COUNT=4.
- Taken branch: at PC=5, BRANCH=1, TAKEN=1, OFFSET=8'hFD -> next FETCH PC=2. Same with TAKEN=0 -> PC=6.
- Stall: STALL=1 for 3 cycles in EXEC at PC=7 -> INSTRUCTION, PC and count held; INSTR_VALID stays 1; resumes to PC=8 after release.
- Wrap: START_ADDR=1023, non-branch -> next PC=0. Taken branch at PC=1 with OFFSET=-2 -> PC=1023.
- Reset mid-op: RESET_N low during EXEC at PC=9 -> immediately state IDLE, INSTR_VALID=0, PC=START_ADDR, count=0. START ignored while reset asserted.
- Restart: START while in FETCH -> ignored. START while HALTED -> PC=START_ADDR, count cleared, DONE falls.
